// File: rtl/rom_arb_pkg.sv
// Shared types and default sizing for the ROM arbiter slice.
package rom_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   localparam int NREQ_DEF = 4;
   localparam int AW_DEF   = 4;
   localparam int DW_DEF   = 8;

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after ptr wins.
module rr_pick
   import rom_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      ptr,
   output logic [NREQ-1:0] gnt,
   output logic [2:0]      idx
);

   // Rank each requester by its distance after ptr; lowest ranked active one wins.
   always_comb begin
      int unsigned d;
      int unsigned best;
      int unsigned best_d;
      d      = 0;
      best   = 0;
      best_d = NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req[i]) begin
            d = (i + NREQ - 1 - 32'(ptr)) % NREQ;
            if (d < best_d) begin
               best_d = d;
               best   = i;
            end
         end
      end
      gnt = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         gnt[i] = (best_d < NREQ) && (best == i);
      end
      idx = 3'(best);
   end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one registered-output ROM port.
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*AW-1:0] len,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rvalid,
   output logic [DW-1:0]     rdata,
   output logic              busy,
   output logic [2:0]        owner,
   output logic              rom_re,
   output logic [AW-1:0]     rom_addr,
   input  logic [DW-1:0]     rom_data
);

   localparam logic [AW-1:0] ONE = AW'(1);

   arb_state_t        state, state_n;
   logic [2:0]        ptr, ptr_n;
   logic [2:0]        owner_n;
   logic [AW-1:0]     cur, cur_n;
   logic [AW-1:0]     cnt, cnt_n;
   logic [NREQ-1:0]   rvalid_n;

   logic [NREQ-1:0]   pick_gnt;
   logic [2:0]        pick_idx;
   logic [AW-1:0]     sel_addr;
   logic [AW-1:0]     sel_len;

   rr_pick #(
      .NREQ(NREQ)
   ) u_pick (
      .req(req),
      .ptr(ptr),
      .gnt(pick_gnt),
      .idx(pick_idx)
   );

   // Route the winner's start address and length fields.
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_idx == 3'(i)) begin
            sel_addr = addr[i*AW +: AW];
            sel_len  = len[i*AW +: AW];
         end
      end
   end

   // Next-state, grant and ROM port control; everything held quiet during reset.
   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      owner_n  = owner;
      cur_n    = cur;
      cnt_n    = cnt;
      gnt      = '0;
      rom_re   = 1'b0;
      rom_addr = '0;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  gnt      = pick_gnt;
                  rom_re   = 1'b1;
                  rom_addr = sel_addr;
                  ptr_n    = pick_idx;
                  owner_n  = pick_idx;
                  cur_n    = sel_addr + ONE;
                  cnt_n    = sel_len;
                  if (sel_len != '0) state_n = ST_BURST;
               end
            end
            ST_BURST: begin
               rom_re   = 1'b1;
               rom_addr = cur;
               cur_n    = cur + ONE;
               cnt_n    = cnt - ONE;
               if (cnt == ONE) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // The read issued this cycle belongs to owner_n (the new winner in IDLE, the holder in BURST).
   always_comb begin
      rvalid_n = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         rvalid_n[i] = rom_re && (owner_n == 3'(i));
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         ptr    <= 3'(NREQ - 1);
         owner  <= '0;
         cur    <= '0;
         cnt    <= '0;
         rvalid <= '0;
      end else begin
         state  <= state_n;
         ptr    <= ptr_n;
         owner  <= owner_n;
         cur    <= cur_n;
         cnt    <= cnt_n;
         rvalid <= rvalid_n;
      end
   end

   assign busy  = (state == ST_BURST);
   assign rdata = rom_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a read-queue reference model.
module tb_rom_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 4;
   localparam int DW   = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*AW-1:0] addr = '0;
   logic [NREQ*AW-1:0] len = '0;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   rvalid;
   logic [DW-1:0]     rdata;
   logic              busy;
   logic [2:0]        owner;
   logic              rom_re;
   logic [AW-1:0]     rom_addr;
   logic [DW-1:0]     rom_data = '0;

   int n_cmp = 0;
   int n_bad = 0;

   rom_arbiter #(
      .NREQ(NREQ),
      .AW(AW),
      .DW(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .addr(addr),
      .len(len),
      .gnt(gnt),
      .rvalid(rvalid),
      .rdata(rdata),
      .busy(busy),
      .owner(owner),
      .rom_re(rom_re),
      .rom_addr(rom_addr),
      .rom_data(rom_data)
   );

   always #5 clk = ~clk;

   // ROM contents: 2^a for a<8, 2^(a-7)-1 above.
   function automatic logic [7:0] rom_tbl(input logic [3:0] a);
      int v;
      if (a < 8) v = 1 << a;
      else       v = (1 << (a - 7)) - 1;
      return 8'(v);
   endfunction

   // External 16x8 ROM with registered, read-enable gated output.
   always @(posedge clk) if (rom_re) rom_data <= rom_tbl(rom_addr);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: each grant expands into a queue of reads, one per cycle.
   typedef struct {
      logic [3:0] a;
      int         o;
      bit         first;
   } rd_t;

   rd_t q[$];
   int  m_last = NREQ - 1;
   int  m_owner = 0;
   bit  have_prev = 0;
   rd_t prev;
   bit  started = 0;

   always @(negedge clk) begin
      rd_t e;
      int  w;
      logic [NREQ-1:0] exp_gnt;
      exp_gnt = '0;
      if (!rst && q.size() == 0 && req != '0) begin
         w = -1;
         for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (w < 0 && req[i]) w = i;
         end
         exp_gnt[w] = 1'b1;
         for (int j = 0; j <= int'(len[w*AW +: AW]); j++) begin
            e.a = 4'(int'(addr[w*AW +: AW]) + j);
            e.o = w;
            e.first = (j == 0);
            q.push_back(e);
         end
      end
      if (started) begin
         check("gnt", 32'(gnt), 32'(exp_gnt));
         check("rom_re", 32'(rom_re), (!rst && q.size() > 0) ? 1 : 0);
         if (!rst) check("rom_addr", 32'(rom_addr), (q.size() > 0) ? 32'(q[0].a) : 0);
         check("busy", 32'(busy), (q.size() > 0 && !q[0].first) ? 1 : 0);
         check("owner", 32'(owner), 32'(m_owner));
         check("rvalid", 32'(rvalid), have_prev ? (1 << prev.o) : 0);
         if (have_prev) check("rdata", 32'(rdata), 32'(rom_tbl(prev.a)));
      end
      if (rst) begin
         q.delete();
         m_last = NREQ - 1;
         m_owner = 0;
         have_prev = 0;
         started = 1;
      end else if (q.size() > 0) begin
         prev = q.pop_front();
         have_prev = 1;
         if (prev.first) begin
            m_last = prev.o;
            m_owner = prev.o;
         end
      end else begin
         have_prev = 0;
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] l);
      addr[i*AW +: AW] = a;
      len[i*AW +: AW]  = l;
   endtask

   // Directed scenarios with hand-computed literal expectations.
   initial begin
      int bcnt;
      logic [7:0] exp_seq [4];
      logic [3:0] exp_g [5];
      logic [3:0] last_g;
      exp_seq[0] = 8'h7F; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h01; exp_seq[3] = 8'h02;
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

      rst = 1'b1;
      repeat (3) nxt();
      rst = 1'b0;
      mid();
      check("reset_rvalid", 32'(rvalid), 0);
      check("reset_owner", 32'(owner), 0);
      check("reset_busy", 32'(busy), 0);

      // Single read from requester 0 at address 3.
      nxt();
      set_req(0, 4'd3, 4'd0);
      req = 4'b0001;
      mid();
      check("t1_gnt", 32'(gnt), 32'b0001);
      check("t1_rom_addr", 32'(rom_addr), 3);
      nxt();
      req = '0;
      mid();
      check("t1_rvalid", 32'(rvalid), 32'b0001);
      check("t1_rdata", 32'(rdata), 32'h08);
      check("t1_busy", 32'(busy), 0);

      // Four-word wrapping burst from requester 1 at 14.
      nxt();
      set_req(1, 4'd14, 4'd3);
      req = 4'b0010;
      mid();
      check("t2_gnt", 32'(gnt), 32'b0010);
      bcnt = int'(busy);
      nxt();
      req = '0;
      for (int k = 0; k < 4; k++) begin
         mid();
         check("t2_rvalid", 32'(rvalid), 32'b0010);
         check("t2_rdata", 32'(rdata), 32'(exp_seq[k]));
         bcnt += int'(busy);
         if (k < 3) nxt();
      end
      check("t2_busy_cycles", 32'(bcnt), 3);

      // All four requesting single reads after a fresh reset: strict rotation.
      nxt();
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 4), 4'd0);
      req = 4'b1111;
      last_g = '0;
      for (int k = 0; k < 5; k++) begin
         mid();
         check("t3_gnt", 32'(gnt), 32'(exp_g[k]));
         check("t3_rvalid", 32'(rvalid), 32'(last_g));
         last_g = gnt;
         nxt();
      end
      req = '0;
      mid();
      check("t3_rvalid_last", 32'(rvalid), 32'b0001);

      // 16-word burst from requester 0; requester 2 arrives mid-burst and waits.
      nxt();
      set_req(0, 4'd0, 4'd15);
      set_req(2, 4'd9, 4'd1);
      req = 4'b0001;
      mid();
      check("t4_gnt0", 32'(gnt), 32'b0001);
      nxt();
      req = '0;
      mid();
      check("t4_gnt_hold", 32'(gnt), 0);
      nxt();
      req = 4'b0100;
      for (int k = 2; k < 16; k++) begin
         mid();
         check("t4_gnt_hold", 32'(gnt), 0);
         check("t4_rom_addr", 32'(rom_addr), k);
         nxt();
      end
      mid();
      check("t4_gnt2", 32'(gnt), 32'b0100);
      check("t4_rom_addr2", 32'(rom_addr), 9);
      check("t4_rvalid_last0", 32'(rvalid), 32'b0001);
      check("t4_rdata_last0", 32'(rdata), 32'hFF);
      nxt();
      req = '0;
      mid();
      check("t4_rvalid2", 32'(rvalid), 32'b0100);
      check("t4_rdata2", 32'(rdata), 32'h03);

      // Reset during the third cycle of an 8-word burst from requester 1.
      nxt();
      nxt();
      set_req(1, 4'd5, 4'd7);
      req = 4'b0010;
      mid();
      check("t5_gnt", 32'(gnt), 32'b0010);
      nxt();
      req = '0;
      nxt();
      rst = 1'b1;
      mid();
      check("t5_rst_rom_re", 32'(rom_re), 0);
      nxt();
      rst = 1'b0;
      mid();
      check("t5_rvalid", 32'(rvalid), 0);
      check("t5_busy", 32'(busy), 0);
      check("t5_rom_re", 32'(rom_re), 0);
      nxt();
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_req(i, 4'(i), 4'd0);
      mid();
      check("t5_gnt_after", 32'(gnt), 32'b0001);
      nxt();
      req = '0;
      repeat (3) nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter and burst sequencer that shares one synchronous-read ROM port (16x8, registered output, read-enable gated) among NREQ requesters. Each requester issues a start address and burst length. The arbiter grants one requester at a time, drives consecutive ROM reads (wrapping mod 2^AW), and routes a one-cycle-latency valid strobe back to the owner. It sits between client engines (pattern players, table lookups) and the ROM instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- AW, 4: ROM address width; also the burst-length field width.
- DW, 8: ROM data width.
- clk  in  1: clock; all logic on posedge.
- rst  in  1: synchronous, active-high reset.
- req  in  NREQ: request valid per requester; held with addr/len stable until its gnt bit is seen.
- addr  in  NREQ*AW: start address, requester i at [i*AW +: AW].
- len  in  NREQ*AW: burst length minus one, requester i at [i*AW +: AW]; 0 means a single read, 15 means 16 reads.
- gnt  out  NREQ: one-hot, combinational, one-cycle acceptance pulse.
- rvalid  out  NREQ: registered, one-hot; data on rdata is valid for requester i.
- rdata  out  DW: pass-through of rom_data, shared by all requesters.
- busy  out  1: registered; high while in BURST.
- owner  out  3: registered index of the last granted requester.
- rom_re  out  1: ROM read enable, combinational.
- rom_addr  out  AW: ROM address, combinational.
- rom_data  in  DW: ROM registered output, valid the cycle after rom_re.

## Operation
- State machine with two states: IDLE and BURST. Registers: state, ptr (last winner), cur (next address), cnt, owner, rvalid.
- **IDLE**
  - If any req is high, pick winner w as the first requester with req high, scanning ptr+1, ptr+2, … mod NREQ.
  - In the same cycle: gnt[w]=1, rom_re=1, rom_addr=addr[w].
  - At the clock edge: ptr<=w, owner<=w, cur<=addr[w]+1 mod 2^AW, cnt<=len[w].
  - If len[w]==0, stay in IDLE. Otherwise go to BURST.
  - If no req is high: gnt=0, rom_re=0, rom_addr=0.
- **BURST**
  - rom_re=1, rom_addr=cur. At the edge: cur<=cur+1 (wraps 15->0), cnt<=cnt-1.
  - When cnt==1, go to IDLE at the edge.
  - All req inputs are ignored and gnt=0.
- A request with len L produces exactly L+1 reads at addr, addr+1, … mod 2^AW, on consecutive cycles with no gaps.
- rvalid[owner-of-read]<=rom_re at each edge, so rvalid is high in the cycle after each read. All other rvalid bits are 0.
- rdata=rom_data at all times. It is meaningful only where rvalid is set.
- After a grant, the requester deasserts req in the next cycle or presents a new request. A still-high req is treated as a new request.
- The IDLE cycle after a burst may grant immediately, so there are no dead cycles between bursts.
- **Reset** (applies mid-burst too):
  - state=IDLE, ptr=NREQ-1 (requester 0 wins first), cur=0, cnt=0, owner=0, rvalid=0, busy=0.
  - gnt and rom_re are forced to 0 while rst is high.
  - An aborted burst produces no further rvalid.

## Timing
- Grant latency: 0 cycles. gnt is in the same cycle as the first rom_re.
- Data latency: rvalid is 1 cycle after the corresponding rom_re.
- Burst of L+1 words: rom_re is high for cycles N..N+L and rvalid for N+1..N+L+1.
- busy is high in cycles N+1..N+L. It is never set for L=0.
- Throughput: one ROM read per cycle, sustained across back-to-back grants to different requesters.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait. With all requesters active, grants rotate 0,1,2,3,0…
- The combinational path is req/addr to gnt/rom_addr. There is no combinational path from rom_data to any control output.

## Structure
- Shared package rom_arb_pkg holds the state enum (ST_IDLE, ST_BURST) and default constants NREQ_DEF, AW_DEF, DW_DEF.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req[NREQ] and ptr. Outputs are a one-hot grant and its index.
- The ROM is not instantiated inside. The top level connects rom_re/rom_addr/rom_data to the existing 16x8 ROM.

## Test plan
- After reset, req=0001, addr0=3, len0=0: gnt=0001 and rom_addr=3 in the same cycle. Next cycle rvalid=0001 and rdata=ROM[3]=8'h08. busy stays 0.
- req=0010, addr1=14, len1=3: reads at 14, 15, 0, 1. rdata sequence 7F, FF, 01, 02 with rvalid=0010 on four consecutive cycles. busy is high for 3 cycles.
- req=1111 held, all len=0: gnt order 0001, 0010, 0100, 1000, 0001. rvalid follows one cycle later.
- Requester 0 in a 16-word burst from 0 while req2 rises mid-burst: gnt2 is withheld until the IDLE cycle right after the 16th read. The first read for requester 2 follows with no gap.
- rst asserted during the 3rd cycle of an 8-word burst: the next cycle has rvalid=0, busy=0, rom_re=0, and subsequent grants start from requester 0.
